// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//
// Inter-stage pipeline register. It latches 1..LANES issue lanes of payload
// from one stage into the next stage. Its behaviour is set by the global
// stall vector and by the flush line.
//
// Each edge applies exactly one action, highest priority first:
//   reset   -> lanes empty (NOP_VAL), sticky 0, counter 0
//   flush   -> lanes empty, sticky 0, counter kept
//   bubble  -> upstream stalled, downstream running: lanes empty,
//              sticky held, counter + 1 (saturating)
//   advance -> upstream running: load inputs, and scrub invalid lanes
//              to NOP_VAL
//   hold    -> both stalled: everything keeps its value
// cnt_clr zeroes the bubble counter. It outranks the increment and it also
// applies during flush.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   stall       global stall vector; bit i freezes stage i
//   flush       kills the register contents
//   cnt_clr     clears bubble_cnt
//   in_valid    per-lane valid from the upstream stage
//   in_data     lane payloads, lane 0 in the low DATA_W bits
//   in_sticky   side-channel flag
//   out_valid   registered lane valids
//   out_data    registered lane payloads
//   out_sticky  registered side-channel flag
//   bubble_cnt  saturating count of bubble cycles inserted
//
// Every output comes straight from a flop. No input has a combinational
// path to an output.
module pipe_stage_reg #(
  parameter int                 DATA_W  = 32,
  parameter int                 LANES   = 1,
  parameter int                 STALL_W = 6,
  parameter int                 STAGE   = 2,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic                      cnt_clr,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_sticky,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_sticky,
  output logic [CNT_W-1:0]          bubble_cnt
);

  logic up;
  logic dn;
  logic bubble;
  logic advance;
  // Only two bits of the stall vector matter to this boundary. The other
  // bits are folded here so that they count as consumed.
  logic stall_unused;

  assign up = stall[STAGE];

  // The last stage has no downstream stage, so it can never be held by one.
  generate
    if (STAGE < STALL_W - 1) begin : g_dn
      assign dn = stall[STAGE+1];
    end else begin : g_dn_last
      assign dn = 1'b0;
    end
  endgenerate

  assign stall_unused = ^stall;

  // up=0 with dn=1 is an illegal encoding. It falls into advance here.
  assign bubble  = up & ~dn;
  assign advance = ~up;

  logic [LANES-1:0]        valid_reg;
  logic [LANES*DATA_W-1:0] data_reg;
  logic                    sticky_reg;
  logic [CNT_W-1:0]        cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
          valid_reg[gi]                    <= 1'b0;
          data_reg[gi*DATA_W +: DATA_W]    <= NOP_VAL;
        end else if (advance) begin
          valid_reg[gi]                    <= in_valid[gi];
          // An invalid lane carries NOP_VAL, never stale upstream data.
          data_reg[gi*DATA_W +: DATA_W]    <= in_valid[gi] ? in_data[gi*DATA_W +: DATA_W]
                                                           : NOP_VAL;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      sticky_reg <= 1'b0;
    end else if (advance) begin
      sticky_reg <= in_sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_reg <= '0;
    end else if (!flush && bubble && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_valid  = valid_reg;
  assign out_data   = data_reg;
  assign out_sticky = sticky_reg;
  assign bubble_cnt = cnt_reg;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the OpenMIPS core. It generalises the fixed decode/execute latch to any stage boundary, any payload width and 1..N issue lanes, and adds per-lane valid tracking, NOP scrubbing of invalid lanes, a sticky side-channel bit, and a saturating bubble counter for performance monitoring. One instance sits between each pair of adjacent pipeline stages and is driven by the shared `ctrl` stall vector and flush line.

## Interface
Parameters:
- `DATA_W`, 32: payload width per lane.
- `LANES`, 1: issue lanes, 1..4.
- `STALL_W`, 6: width of the global stall vector.
- `STAGE`, 2: index of this register's upstream stage in `stall`; legal range 0..STALL_W-1.
- `NOP_VAL`, 0: `DATA_W`-bit payload value loaded into empty or killed lanes.
- `CNT_W`, 16: bubble counter width.

Ports:
- `clk`  in  1  rising-edge clock, sole clock.
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1'b1); sampled only at `posedge clk`.
- `stall`  in  STALL_W  global stall vector; bit i = 1 (`Stop`) freezes stage i.
- `flush`  in  1  exception/eret flush; kills the register contents.
- `cnt_clr`  in  1  clears `bubble_cnt`.
- `in_valid`  in  LANES  per-lane valid from the upstream stage.
- `in_data`  in  LANES*DATA_W  lane payloads, lane 0 in bits [DATA_W-1:0].
- `in_sticky`  in  1  side-channel flag, e.g. next-instruction-in-delay-slot.
- `out_valid`  out  LANES  registered lane valids.
- `out_data`  out  LANES*DATA_W  registered lane payloads.
- `out_sticky`  out  1  registered side-channel flag.
- `bubble_cnt`  out  CNT_W  count of bubble cycles inserted.

## Operation
- Signal definitions: `up = stall[STAGE]`. `dn = stall[STAGE+1]` when `STAGE < STALL_W-1`; otherwise `dn = 0`.
- Each rising edge applies exactly one action, in this priority order:
  1. **RESET** (`rst`=1): `out_valid`=0, every lane of `out_data`=`NOP_VAL`, `out_sticky`=0, `bubble_cnt`=0.
  2. **FLUSH** (`flush`=1): `out_valid`=0, all lanes=`NOP_VAL`, `out_sticky`=0. `bubble_cnt` is unchanged, apart from `cnt_clr` below.
  3. **BUBBLE** (`up`=1, `dn`=0): `out_valid`=0, all lanes=`NOP_VAL`. `out_sticky` holds. `bubble_cnt` increments.
  4. **ADVANCE** (`up`=0):
     - Lane k: `out_valid[k]` = `in_valid[k]`.
     - Lane k: `out_data` lane k = `in_data` lane k if `in_valid[k]`, else `NOP_VAL` (scrubbing).
     - `out_sticky` = `in_sticky`.
  5. **HOLD** (`up`=1, `dn`=1): all outputs keep their values.
- `up`=0 with `dn`=1 is an illegal `ctrl` encoding. The register treats it as ADVANCE; the bench asserts that it never occurs.
- Bubble counter:
  - Saturates at all-ones and never wraps.
  - `cnt_clr`=1 forces 0 on the next edge.
  - `cnt_clr` outranks the increment, and also applies during FLUSH.
  - Only `rst` and `cnt_clr` clear the counter.
- Outputs are pure flops. There is no combinational path from any input to any output.

## Timing
- Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- Reset value of every output is as listed under RESET. Reset takes effect on the first edge with `rst`=1, mid-operation included, and discards any HOLD state.
- FLUSH together with any stall pattern: FLUSH wins, and `bubble_cnt` does not increment.
- RESET together with FLUSH or `cnt_clr`: RESET wins, and the counter ends at 0.
- HOLD lasting N cycles: outputs are stable for N cycles. The first ADVANCE afterwards loads the current inputs.
- Back-to-back BUBBLE cycles increment the counter once per cycle.
- `STAGE = STALL_W-1`: BUBBLE occurs whenever `up`=1, and HOLD is unreachable.

## Test plan
1. **Reset.** Hold `rst`=1 for 2 cycles with `LANES`=2 and `NOP_VAL`=0.
   - Required: `out_valid`=2'b00, `out_data`=0, `out_sticky`=0, `bubble_cnt`=0.
   - Then release reset and ADVANCE with `in_valid`=2'b11, `in_data`={32'hDEADBEEF, 32'h00000001}, `in_sticky`=1.
   - Required: the same values appear one cycle later.
2. **Scrubbing.** ADVANCE with `in_valid`=2'b01 and `in_data`={32'h12345678, 32'hAAAA5555}.
   - Required: lane 0 = 32'hAAAA5555, lane 1 = 0, `out_valid`=2'b01.
3. **Bubble versus hold** (`STAGE`=2).
   - Load 32'hCAFE0000, then drive `stall`=6'b000100 for 3 cycles.
   - Required: `out_valid`=0, `out_data`=`NOP_VAL`, `bubble_cnt`=3, `out_sticky` unchanged.
   - Then reload and drive `stall`=6'b001100 for 3 cycles.
   - Required: outputs hold 32'hCAFE0000 and `bubble_cnt` stays 3.
4. **Flush priority.**
   - `flush`=1 with `stall`=6'b000100 and `bubble_cnt`=5. Required: outputs cleared, `out_sticky`=0, `bubble_cnt` stays 5.
   - `flush`=1 with `cnt_clr`=1. Required: `bubble_cnt`=0.
5. **Saturation.** With `CNT_W`=4, drive 20 consecutive BUBBLE cycles.
   - Required: `bubble_cnt` reaches 4'hF at cycle 15 and stays there.
   - Then `cnt_clr`=1. Required: `bubble_cnt`=0 on the next cycle.
6. **Reset mid-hold.** While in HOLD with `out_valid`=1, assert `rst` for 1 cycle.
   - Required: all outputs at reset values after that edge.
   - Then ADVANCE. Required: normal operation resumes with 1-cycle latency.
